// File: rtl/twos_pkg.sv
// Shared definitions for the serial two's-complement decoder/encoder family:
// FSM encoding, default word width and a counter-width helper.
package twos_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int TWOS_WIDTH = 6;

    // Bits needed to count 0..value-1; never less than one.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/twos_to_signmag_serial_cell.sv
// One-bit "copy up to the first 1, invert afterwards" complement cell.
// Reusable by a serial two's-complement encoder as well as the decoder.
module serial_complement_cell (
    input  logic clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    input  logic b,
    input  logic sign,
    output logic out_bit,
    output logic seen_one
);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            seen_one <= 1'b0;
        else if (clr)
            seen_one <= 1'b0;
        else if (en)
            seen_one <= seen_one | b;
    end

    assign out_bit = sign ? (b ^ seen_one) : b;

endmodule

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign/magnitude decoder, LSB first.
// Define TWOS_DEC_SAT_EN to saturate the most-negative input to 2^(WIDTH-1)-1.
module twos_to_signmag_serial
    import twos_pkg::*;
#(
    parameter int WIDTH = TWOS_WIDTH
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic             Sign,
    output logic [WIDTH-1:0] Magnitude,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             Overflow
);

    localparam int CW = clog2(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             out_bit;
    logic             seen_one;
    logic             accept;
    logic             shift_en;
    logic             last;

    assign In_Ready  = (state == IDLE) && !Reset;
    assign Out_Valid = (state == DONE);
    assign accept    = In_Valid && In_Ready;
    assign shift_en  = (state == SHIFT);
    assign last      = shift_en && (cnt == CW'(WIDTH - 1));

    serial_complement_cell u_cell (
        .clk      (clk),
        .Reset    (Reset),
        .clr      (accept),
        .en       (shift_en),
        .b        (sreg[0]),
        .sign     (Sign),
        .out_bit  (out_bit),
        .seen_one (seen_one)
    );

`ifdef TWOS_DEC_SAT_EN
    // Only the most-negative word reaches its sign bit without a prior 1.
    logic sat_hit;
    logic ovf;
    assign sat_hit  = last && sreg[0] && !seen_one;
    assign Overflow = ovf;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            ovf <= 1'b0;
        else if (accept || (Out_Valid && Out_Ready))
            ovf <= 1'b0;
        else if (sat_hit)
            ovf <= 1'b1;
    end
`else
    logic unused_seen;
    assign unused_seen = seen_one;
    assign Overflow    = 1'b0;
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            Sign      <= 1'b0;
            Magnitude <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg  <= In_Data;
                        Sign  <= In_Data[WIDTH-1];
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg      <= {1'b0, sreg[WIDTH-1:1]};
                    Magnitude <= {out_bit, Magnitude[WIDTH-1:1]};
                    cnt       <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
`ifdef TWOS_DEC_SAT_EN
                        if (sat_hit)
                            Magnitude <= {1'b0, {(WIDTH-1){1'b1}}};
`endif
                    end
                end
                DONE: begin
                    if (Out_Ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed bench for twos_to_signmag_serial at WIDTH=6: vector table plus
// reset, backpressure and back-to-back sequences.
module tb_twos_to_signmag_serial;

    localparam int W = 6;

    logic         clk;
    logic         Reset;
    logic [W-1:0] In_Data;
    logic         In_Valid;
    logic         In_Ready;
    logic         Sign;
    logic [W-1:0] Magnitude;
    logic         Out_Valid;
    logic         Out_Ready;
    logic         Overflow;

    int n_cmp;
    int n_err;
    int cyc;

    twos_to_signmag_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .In_Data   (In_Data),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Sign      (Sign),
        .Magnitude (Magnitude),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Overflow  (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] din;
        logic         sign;
        logic [W-1:0] mag;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];

`ifdef TWOS_DEC_SAT_EN
    localparam logic [W-1:0] MOSTNEG_MAG = 6'd31;
    localparam logic         MOSTNEG_OVF = 1'b1;
`else
    localparam logic [W-1:0] MOSTNEG_MAG = 6'd32;
    localparam logic         MOSTNEG_OVF = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    // Present one operand, return edges from accept to Out_Valid (accept edge counts as 1).
    task automatic do_op(input logic [W-1:0] d, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!In_Ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 0, 1);
        In_Data  = d;
        In_Valid = 1'b1;
        @(posedge clk);
        #1 In_Valid = 1'b0;
        lat = 1;
        while (!Out_Valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int cnt_bad;
        int t_prev;
        logic         s_hold;
        logic [W-1:0] m_hold;
        logic [W-1:0] b2b_in[4];
        logic         b2b_s[4];
        logic [W-1:0] b2b_m[4];

        n_cmp = 0; n_err = 0; cyc = 0;
        vecs[0] = '{"pos13",   6'd13,      1'b0, 6'd13,       1'b0};
        vecs[1] = '{"neg13",   6'b110011,  1'b1, 6'd13,       1'b0};
        vecs[2] = '{"neg1",    6'b111111,  1'b1, 6'd1,        1'b0};
        vecs[3] = '{"zero",    6'b000000,  1'b0, 6'd0,        1'b0};
        vecs[4] = '{"maxpos",  6'b011111,  1'b0, 6'd31,       1'b0};
        vecs[5] = '{"mostneg", 6'b100000,  1'b1, MOSTNEG_MAG, MOSTNEG_OVF};
        vecs[6] = '{"pos1",    6'b000001,  1'b0, 6'd1,        1'b0};
        vecs[7] = '{"neg2",    6'b111110,  1'b1, 6'd2,        1'b0};
        vecs[8] = '{"neg19",   6'b101101,  1'b1, 6'd19,       1'b0};

        Reset = 1'b1; In_Data = '0; In_Valid = 1'b0; Out_Ready = 1'b1;
        #12;
        check("rst_in_ready",  In_Ready,  0);
        check("rst_out_valid", Out_Valid, 0);
        check("rst_sign",      Sign,      0);
        check("rst_mag",       Magnitude, 0);
        check("rst_ovf",       Overflow,  0);
        @(negedge clk);
        Reset = 1'b0;
        #1 check("rel_in_ready", In_Ready, 1);

        // Table vectors with immediate handoff.
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].din, lat);
            check({vecs[i].name, "_lat"},  lat,       W + 1);
            check({vecs[i].name, "_sign"}, Sign,      vecs[i].sign);
            check({vecs[i].name, "_mag"},  Magnitude, vecs[i].mag);
            check({vecs[i].name, "_ovf"},  Overflow,  vecs[i].ovf);
            @(posedge clk);
            #1 check({vecs[i].name, "_handoff"}, Out_Valid, 0);
        end

        // Backpressure: hold result 5 cycles while a new operand is offered.
        @(negedge clk);
        Out_Ready = 1'b0;
        do_op(6'b111011, lat);
        check("bp_lat", lat, W + 1);
        s_hold = Sign; m_hold = Magnitude;
        check("bp_sign", s_hold, 1);
        check("bp_mag",  m_hold, 5);
        @(negedge clk);
        In_Data = 6'd9; In_Valid = 1'b1;
        cnt_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!Out_Valid || In_Ready || Sign !== s_hold || Magnitude !== m_hold) cnt_bad++;
        end
        check("bp_stable", cnt_bad, 0);
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel_valid", Out_Valid, 0);
        check("bp_rel_ready", In_Ready,  1);
        check("bp_keep_mag",  Magnitude, 5);
        check("bp_rel_ovf",   Overflow,  0);

        // Back-to-back stream with In_Valid and Out_Ready held high.
        b2b_in = '{6'b111111, 6'b000001, 6'b100000, 6'b011111};
        b2b_s  = '{1'b1, 1'b0, 1'b1, 1'b0};
        b2b_m  = '{6'd1, 6'd1, MOSTNEG_MAG, 6'd31};
        @(negedge clk);
        In_Data = b2b_in[0]; In_Valid = 1'b1;
        t_prev = -1;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            @(posedge clk);
            #1;
            while (!Out_Valid && n < 30) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 30) check("b2b_timeout", 0, 1);
            check("b2b_sign", Sign,      b2b_s[k]);
            check("b2b_mag",  Magnitude, b2b_m[k]);
            if (t_prev >= 0) check("b2b_spacing", cyc - t_prev, W + 2);
            t_prev = cyc;
            if (k < 3) In_Data = b2b_in[k + 1];
            else       In_Valid = 1'b0;
        end
        @(posedge clk);
        #1 check("b2b_end_valid", Out_Valid, 0);

        // Reset in the middle of a shift: no result may appear.
        @(negedge clk);
        In_Data = 6'b101101; In_Valid = 1'b1;
        @(posedge clk);
        #1 In_Valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 Reset = 1'b1;
        #1;
        check("mid_rst_in_ready",  In_Ready,  0);
        check("mid_rst_out_valid", Out_Valid, 0);
        check("mid_rst_mag",       Magnitude, 0);
        check("mid_rst_sign",      Sign,      0);
        @(negedge clk);
        Reset = 1'b0;
        #1 check("mid_rel_in_ready", In_Ready, 1);
        cnt_bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (Out_Valid) cnt_bad++;
        end
        check("mid_rst_no_result", cnt_bad, 0);
        check("mid_rst_mag_hold",  Magnitude, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, wanted finished");
        $fatal(1, "timeout");
    end

endmodule
